moon_hit_detector: RTL and testbench

Per-frame collision judge between the player sprite and the chasing moon enemy. Consumes the moon's per-pixel coverage flag (`moon_on`) and the player's equivalent while the VGA scan runs. Accumulates overlapping playfield pixels, decides at each frame boundary whether the player was hit, and owns lives, invulnerability frames, blink and game-over state for the renderer and top-level game FSM.

---
 rtl/moon_hit_detector.sv | 157 +++++++++++++++
 tb/tb_moon_hit_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moon_hit_detector.sv
// moon_hit_detector
// Per-frame collision judge between the player sprite and the moon enemy.
// Counts overlapping playfield pixels during the scan, evaluates the count
// at each frame boundary and owns lives, invulnerability, blink and
// game-over state.
//
// Ports:
//   clk            : system clock
//   reset          : asynchronous, active-high reset
//   pix_tick       : pixel strobe, pixel inputs sampled only when high
//   x, y           : current scan coordinates (10 bit)
//   player_on      : player sprite opaque at (x,y)
//   moon_on        : moon sprite opaque at (x,y)
//   frame_start    : single-cycle frame boundary pulse
//   restart        : single-cycle game restart pulse
//   lives          : remaining lives
//   hit            : one-cycle pulse when a hit is registered
//   invuln         : high while invulnerable
//   player_visible : renderer gate for the player sprite
//   game_over      : high once lives reach 0
module moon_hit_detector #(
    parameter int MAX_X         = 384,
    parameter int MAX_Y         = 448,
    parameter int LIVES_INIT    = 3,
    parameter int HIT_THRESHOLD = 16,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_PERIOD  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       player_on,
    input  logic       moon_on,
    input  logic       frame_start,
    input  logic       restart,
    output logic [2:0] lives,
    output logic       hit,
    output logic       invuln,
    output logic       player_visible,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_INVULN    = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam logic [10:0] MAX_X_L     = 11'(MAX_X);
    localparam logic [10:0] MAX_Y_L     = 11'(MAX_Y);
    localparam logic [2:0]  LIVES_L     = 3'(LIVES_INIT);
    localparam logic [11:0] THRESH_L    = 12'(HIT_THRESHOLD);
    localparam logic [7:0]  INVULN_L    = 8'(INVULN_FRAMES);
    localparam logic [7:0]  BLINK_END_L = 8'(BLINK_PERIOD - 1);
    localparam logic [11:0] COUNT_MAX   = 12'hFFF;

    state_t     r_state;
    logic [11:0] r_count;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_blink_cnt;
    logic        r_blink;
    logic [2:0]  r_lives;
    logic        r_hit;
    logic        r_invuln;
    logic        r_player_visible;
    logic        r_game_over;

    // A pixel counts only when both sprites cover it inside the playfield.
    logic w_qual;
    assign w_qual = pix_tick & player_on & moon_on &
                    ({1'b0, x} < MAX_X_L) & ({1'b0, y} < MAX_Y_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_ALIVE;
            r_count          <= '0;
            r_frame_cnt      <= '0;
            r_blink_cnt      <= '0;
            r_blink          <= 1'b0;
            r_lives          <= LIVES_L;
            r_hit            <= 1'b0;
            r_invuln         <= 1'b0;
            r_player_visible <= 1'b1;
            r_game_over      <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (restart) begin
                // Restart overrides a coincident frame boundary entirely.
                r_state          <= ST_ALIVE;
                r_count          <= '0;
                r_frame_cnt      <= '0;
                r_blink_cnt      <= '0;
                r_blink          <= 1'b0;
                r_lives          <= LIVES_L;
                r_invuln         <= 1'b0;
                r_player_visible <= 1'b1;
                r_game_over      <= 1'b0;
            end else if (frame_start) begin
                // The boundary-cycle sample already belongs to the new frame.
                r_count <= {11'd0, w_qual};
                case (r_state)
                    ST_ALIVE: begin
                        if (r_count >= THRESH_L) begin
                            r_hit            <= 1'b1;
                            r_player_visible <= 1'b0;
                            if (r_lives > 3'd1) begin
                                r_lives     <= r_lives - 3'd1;
                                r_state     <= ST_INVULN;
                                r_invuln    <= 1'b1;
                                r_frame_cnt <= INVULN_L;
                                r_blink_cnt <= '0;
                                r_blink     <= 1'b0;
                            end else begin
                                r_lives     <= 3'd0;
                                r_state     <= ST_GAME_OVER;
                                r_game_over <= 1'b1;
                            end
                        end
                    end
                    ST_INVULN: begin
                        r_frame_cnt <= r_frame_cnt - 8'd1;
                        if (r_frame_cnt == 8'd1) begin
                            // Last protected frame's overlaps are discarded
                            // by the reload of r_count above.
                            r_state          <= ST_ALIVE;
                            r_invuln         <= 1'b0;
                            r_player_visible <= 1'b1;
                            r_blink_cnt      <= '0;
                            r_blink          <= 1'b0;
                        end else if (r_blink_cnt == BLINK_END_L) begin
                            r_blink_cnt      <= '0;
                            r_blink          <= ~r_blink;
                            r_player_visible <= ~r_blink;
                        end else begin
                            r_blink_cnt      <= r_blink_cnt + 8'd1;
                            r_player_visible <= r_blink;
                        end
                    end
                    default: begin
                        // Game over: nothing changes until restart.
                    end
                endcase
            end else if (w_qual && (r_count != COUNT_MAX)) begin
                r_count <= r_count + 12'd1;
            end
        end
    end

    assign lives          = r_lives;
    assign hit            = r_hit;
    assign invuln         = r_invuln;
    assign player_visible = r_player_visible;
    assign game_over      = r_game_over;

endmodule

// File: tb/tb_moon_hit_detector.sv
// Testbench for moon_hit_detector: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// frame-level behavioural model.
module tb_moon_hit_detector;

    localparam int MAX_X         = 384;
    localparam int MAX_Y         = 448;
    localparam int LIVES_INIT    = 3;
    localparam int HIT_THRESHOLD = 16;
    localparam int INVULN_FRAMES = 120;
    localparam int BLINK_PERIOD  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_tick = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       player_on = 1'b0;
    logic       moon_on = 1'b0;
    logic       frame_start = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] lives;
    logic       hit;
    logic       invuln;
    logic       player_visible;
    logic       game_over;

    moon_hit_detector #(
        .MAX_X(MAX_X), .MAX_Y(MAX_Y), .LIVES_INIT(LIVES_INIT),
        .HIT_THRESHOLD(HIT_THRESHOLD), .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_PERIOD(BLINK_PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .x(x), .y(y),
        .player_on(player_on), .moon_on(moon_on), .frame_start(frame_start),
        .restart(restart), .lives(lives), .hit(hit), .invuln(invuln),
        .player_visible(player_visible), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Game state: 0 alive, 1 invulnerable, 2 game over.
    int m_state, m_lives, m_ov, m_left, m_since;
    bit m_hit;

    initial begin
        forever begin
            bit q;
            @(posedge clk or posedge reset);
            if (reset) begin
                m_state = 0; m_lives = LIVES_INIT; m_ov = 0;
                m_left = 0; m_since = 0; m_hit = 1'b0;
            end else begin
                q = pix_tick && player_on && moon_on &&
                    (int'(x) < MAX_X) && (int'(y) < MAX_Y);
                m_hit = 1'b0;
                if (restart) begin
                    m_state = 0; m_lives = LIVES_INIT; m_ov = 0;
                    m_left = 0; m_since = 0;
                end else if (frame_start) begin
                    if (m_state == 0 &&
                        ((m_ov > 4095) ? 4095 : m_ov) >= HIT_THRESHOLD) begin
                        m_hit = 1'b1;
                        m_lives = m_lives - 1;
                        if (m_lives == 0) m_state = 2;
                        else begin
                            m_state = 1; m_left = INVULN_FRAMES; m_since = 0;
                        end
                    end else if (m_state == 1) begin
                        m_left = m_left - 1;
                        m_since = m_since + 1;
                        if (m_left == 0) m_state = 0;
                    end
                    m_ov = q ? 1 : 0;
                end else begin
                    m_ov = m_ov + (q ? 1 : 0);
                end
            end
        end
    end

    function automatic int exp_visible();
        if (m_state == 0) return 1;
        if (m_state == 1) return (m_since / BLINK_PERIOD) % 2;
        return 0;
    endfunction

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("lives", int'(lives), m_lives);
            check("hit", int'(hit), int'(m_hit));
            check("invuln", int'(invuln), (m_state == 1) ? 1 : 0);
            check("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
            check("player_visible", int'(player_visible), exp_visible());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pix(input bit tk, input bit pl, input bit mo,
                       input int xx, input int yy);
        @(negedge clk);
        pix_tick = tk; player_on = pl; moon_on = mo;
        x = 10'(xx); y = 10'(yy);
        frame_start = 1'b0; restart = 1'b0;
    endtask

    task automatic overlaps(input int n, input int xx, input int yy, input bit tk);
        for (int i = 0; i < n; i++) pix(tk, 1'b1, 1'b1, xx, yy);
    endtask

    // Pulse frame_start (boundary sample empty), return at the negedge
    // where the evaluation result is visible.
    task automatic frame();
        @(negedge clk);
        pix_tick = 1'b0; player_on = 1'b0; moon_on = 1'b0;
        frame_start = 1'b1; restart = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_lives", int'(lives), 3);
        check("rst_visible", int'(player_visible), 1);
        check("rst_hit_inv_go", int'({hit, invuln, game_over}), 0);

        // Threshold boundary: 15 is a miss, 16 is a hit.
        overlaps(15, 10, 10, 1'b1);
        frame();
        check("th15_hit", int'(hit), 0);
        check("th15_lives", int'(lives), 3);
        overlaps(16, 100, 200, 1'b1);
        frame();
        check("th16_hit", int'(hit), 1);
        check("th16_lives", int'(lives), 2);
        check("th16_invuln", int'(invuln), 1);
        check("th16_visible", int'(player_visible), 0);
        pix(0, 0, 0, 0, 0);
        check("hit_one_cycle", int'(hit), 0);

        // Invulnerability with heavy overlap, blink every 8 frames.
        for (int f = 1; f <= 120; f++) begin
            overlaps((f <= 4) ? 500 : 20, 50, 50, 1'b1);
            frame();
            check("inv_no_hit", int'(hit), 0);
            if (f == 7)   check("blink_f7", int'(player_visible), 0);
            if (f == 8)   check("blink_f8", int'(player_visible), 1);
            if (f == 16)  check("blink_f16", int'(player_visible), 0);
            if (f == 119) check("inv_f119", int'(invuln), 1);
            if (f == 120) check("inv_f120", int'(invuln), 0);
        end
        overlaps(16, 0, 0, 1'b1);
        frame();
        check("hit2_lives", int'(lives), 1);

        // Third hit ends the game.
        frames(120);
        overlaps(16, 383, 447, 1'b1);
        frame();
        check("go_lives", int'(lives), 0);
        check("go_flag", int'(game_over), 1);
        check("go_visible", int'(player_visible), 0);
        overlaps(100, 5, 5, 1'b1);
        frame();
        check("go_no_hit", int'(hit), 0);

        // Restart, then restart coincident with frame_start.
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        check("rs_lives", int'(lives), 3);
        check("rs_go", int'(game_over), 0);
        overlaps(20, 7, 7, 1'b1);
        @(negedge clk); frame_start = 1'b1; restart = 1'b1;
        @(negedge clk); frame_start = 1'b0; restart = 1'b0;
        check("rs_fs_hit", int'(hit), 0);
        frame();
        check("rs_fs_next_hit", int'(hit), 0);

        // Qualifiers: out-of-field and untimed overlaps never count.
        overlaps(20, 384, 10, 1'b1);
        overlaps(20, 10, 448, 1'b1);
        overlaps(20, 10, 10, 1'b0);
        for (int i = 0; i < 20; i++) pix(1, 1, 0, 10, 10);
        frame();
        check("qual_no_hit", int'(hit), 0);

        // Saturation still registers a hit.
        overlaps(5000, 1, 1, 1'b1);
        frame();
        check("sat_hit", int'(hit), 1);
        check("sat_lives", int'(lives), 2);

        // Asynchronous reset 40 frames into invulnerability.
        frames(40);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_invuln", int'(invuln), 0);
        check("arst_lives", int'(lives), 3);
        check("arst_visible", int'(player_visible), 1);
        @(negedge clk);
        reset = 1'b0;

        // Randomized play, checked every cycle by the compare process.
        for (int c = 0; c < 14000; c++) begin
            @(negedge clk);
            pix_tick    = ($urandom_range(0, 3) != 0);
            player_on   = ($urandom_range(0, 2) != 0);
            moon_on     = ($urandom_range(0, 2) != 0);
            x           = 10'($urandom_range(370, 400));
            y           = 10'($urandom_range(430, 460));
            frame_start = ($urandom_range(0, 39) == 0);
            restart     = ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        frame_start = 1'b0; restart = 1'b0; pix_tick = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
